// File: rtl/tft_line_fetch.sv
// tft_line_fetch: ping-pong line buffer between a valid/ready frame-buffer pixel
// stream and an 800x480 TFT timing generator. Line n always lives in bank n[0];
// while one bank is shown, the next line is fetched into the other. Panel-facing
// outputs (rgb/de/hs/vs) are aligned to the one-strobe read latency.
module tft_line_fetch #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int PIX_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pix_stb,
  input  logic [9:0]       i_x,
  input  logic [8:0]       i_y,
  input  logic             i_de,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic             i_screenend,
  output logic             o_req,
  output logic [8:0]       o_req_line,
  input  logic [PIX_W-1:0] i_s_data,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  output logic [PIX_W-1:0] o_rgb,
  output logic             o_de,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_underrun
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

  // Fill FSM state
  logic [1:0]       state_q, state_d;
  logic [8:0]       target_q, target_d;
  logic [9:0]       cnt_q, cnt_d;
  logic             req_q, req_d;
  logic [8:0]       req_line_q, req_line_d;
  logic             ready_q, ready_d;
  logic [1:0]       bank_ready_q, bank_ready_d;
  logic [8:0]       bank_line_q [2];
  logic [8:0]       bank_line_d [2];
  logic             underrun_q;

  // Read path state
  logic             de_q, hs_q, vs_q;
  logic             blank_q;
  logic             rgb_en_q;
  logic [PIX_W-1:0] rd_data_q;

  // Two banks of 1024 words each; address = {bank, x}. Words 800..1023 are unused.
  logic [PIX_W-1:0] mem [2048];

  logic             trig_frame, trig_line, trigger, busy_trig;
  logic [8:0]       trig_target;
  logic             wr_fire;
  logic [10:0]      wr_addr, rd_addr;
  logic             first_pix, line_bad, blank_now;

  // Triggers only count on pixel strobes; the falling edge of de is seen against
  // the registered de, which is the previous strobe's value.
  assign trig_frame  = i_pix_stb & i_screenend;
  assign trig_line   = i_pix_stb & de_q & ~i_de & (i_y < Y_LAST);
  assign trigger     = trig_frame | trig_line;
  assign trig_target = trig_frame ? 9'd0 : i_y + 9'd1;
  assign busy_trig   = trigger & (state_q != ST_IDLE);

  assign wr_fire = ready_q & i_s_valid;
  assign wr_addr = {target_q[0], cnt_q};
  assign rd_addr = {i_y[0], i_x};

  // A line is shown only if its bank finished filling with exactly that line.
  assign first_pix = i_pix_stb & i_de & (i_x == 10'd0);
  assign line_bad  = ~bank_ready_q[i_y[0]] | (bank_line_q[i_y[0]] != i_y);
  assign blank_now = first_pix ? line_bad : blank_q;

  // Fill FSM next-state: request one line, then accept exactly H_ACTIVE words
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    req_d        = 1'b0;
    req_line_d   = req_line_q;
    ready_d      = ready_q;
    bank_ready_d = bank_ready_q;
    bank_line_d  = bank_line_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d                      = ST_REQ;
          target_d                     = trig_target;
          req_d                        = 1'b1;
          req_line_d                   = trig_target;
          bank_ready_d[trig_target[0]] = 1'b0;
        end
      end
      ST_REQ: begin
        state_d = ST_FILL;
        cnt_d   = '0;
        ready_d = 1'b1;
      end
      ST_FILL: begin
        if (wr_fire) begin
          if (cnt_q == X_LAST) begin
            ready_d                   = 1'b0;
            state_d                   = ST_IDLE;
            bank_ready_d[target_q[0]] = 1'b1;
            bank_line_d[target_q[0]]  = target_q;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  // Fill FSM and bank bookkeeping registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      target_q       <= '0;
      cnt_q          <= '0;
      req_q          <= 1'b0;
      req_line_q     <= '0;
      ready_q        <= 1'b0;
      bank_ready_q   <= '0;
      bank_line_q[0] <= '0;
      bank_line_q[1] <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      req_line_q   <= req_line_d;
      ready_q      <= ready_d;
      bank_ready_q <= bank_ready_d;
      bank_line_q  <= bank_line_d;
    end
  end

  // Sticky error: a trigger arrived while busy, or a line was not ready in time
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      underrun_q <= 1'b0;
    end else if (busy_trig | (first_pix & line_bad)) begin
      underrun_q <= 1'b1;
    end
  end

  // Line buffer write port
  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      mem[wr_addr] <= i_s_data;
    end
  end

  // Line buffer read port, registered once per pixel strobe
  always_ff @(posedge i_clk) begin
    if (i_pix_stb) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  // Panel-side pipeline: syncs, de and pixel gating delayed by one strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      de_q     <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      blank_q  <= 1'b0;
      rgb_en_q <= 1'b0;
    end else if (i_pix_stb) begin
      de_q     <= i_de;
      hs_q     <= i_hs;
      vs_q     <= i_vs;
      rgb_en_q <= i_de & ~blank_now;
      if (~i_de) begin
        blank_q <= 1'b0;
      end else if (first_pix) begin
        blank_q <= line_bad;
      end
    end
  end

  assign o_req      = req_q;
  assign o_req_line = req_line_q;
  assign o_s_ready  = ready_q;
  assign o_rgb      = rgb_en_q ? rd_data_q : '0;
  assign o_de       = de_q;
  assign o_hs       = hs_q;
  assign o_vs       = vs_q;
  assign o_underrun = underrun_q;

endmodule

// File: tb/tb_tft_line_fetch.sv
// tb_tft_line_fetch: randomized line-fetch bench. A reference model tracks which
// line each bank parity holds and whether a fetch is outstanding; the source
// process serves requested lines with per-line valid patterns.
module tb_tft_line_fetch;

  localparam int H     = 800;
  localparam int V     = 480;
  localparam int BLANK = 900;

  localparam int M_RAND   = 0;
  localparam int M_TOGGLE = 1;
  localparam int M_STALL  = 2;
  localparam int M_FULL   = 3;

  logic        clk = 1'b0;
  logic        i_rst, i_pix_stb, i_de, i_hs, i_vs, i_screenend, i_s_valid;
  logic [9:0]  i_x;
  logic [8:0]  i_y;
  logic [15:0] i_s_data;
  logic        o_req, o_s_ready, o_de, o_hs, o_vs, o_underrun;
  logic [8:0]  o_req_line;
  logic [15:0] o_rgb;

  always #5 clk = ~clk;

  tft_line_fetch #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(16)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_x(i_x), .i_y(i_y),
    .i_de(i_de), .i_hs(i_hs), .i_vs(i_vs), .i_screenend(i_screenend),
    .o_req(o_req), .o_req_line(o_req_line), .i_s_data(i_s_data),
    .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .o_rgb(o_rgb), .o_de(o_de),
    .o_hs(o_hs), .o_vs(o_vs), .o_underrun(o_underrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit          busy;
  int          filled [2];
  bit          exp_underrun;
  bit          prev_de;
  int          act_y;
  bit          line_ok;
  logic [15:0] last_rgb;
  int          exp_req_q [$];
  int          n_req_exp, n_req_seen;

  // Source state
  bit src_en, src_active, pending, src_hold, prev_req, tog;
  int src_line, src_idx;
  int mode_tab [8];
  int release_y;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Content of word idx of frame line 'line' as served by the source
  function automatic logic [15:0] pix(input int line, input int idx);
    logic [31:0] h;
    if (line == 0) return 16'(idx);
    if (line == 1) return 16'h8000 | 16'(idx);
    h = 32'(line) * 32'd40503 + 32'(idx) * 32'd7919 + 32'h1234;
    return h[15:0] ^ 16'(line << 7);
  endfunction

  // One pixel strobe (two clocks): drive timing inputs, predict and check outputs
  task automatic strobe(input logic de, input int x, input int y,
                        input logic hs, input logic vs, input logic se);
    bit          trig;
    int          tl;
    logic [15:0] exp_rgb;
    @(negedge clk);
    chk("rgb_hold", o_rgb, last_rgb);
    i_pix_stb = 1'b1; i_de = de; i_x = 10'(x); i_y = 9'(y);
    i_hs = hs; i_vs = vs; i_screenend = se;
    trig = 1'b0; tl = 0;
    if (se) begin
      trig = 1'b1; tl = 0;
    end else if (prev_de && !de && act_y < V - 1) begin
      trig = 1'b1; tl = act_y + 1;
    end
    if (de) act_y = y;
    prev_de = de;
    if (trig) begin
      if (busy) exp_underrun = 1'b1;
      else begin
        busy = 1'b1;
        filled[tl % 2] = -1;
        exp_req_q.push_back(tl);
        n_req_exp++;
      end
    end
    if (de && x == 0) begin
      line_ok = (filled[y % 2] == y);
      if (!line_ok) exp_underrun = 1'b1;
    end
    exp_rgb = (de && line_ok) ? pix(y, x) : 16'h0;
    @(negedge clk);
    i_pix_stb = 1'b0; i_screenend = 1'b0;
    chk("de", o_de, de);
    chk("hs", o_hs, hs);
    chk("vs", o_vs, vs);
    chk("rgb", o_rgb, exp_rgb);
    chk("underrun", o_underrun, exp_underrun);
    last_rgb = exp_rgb;
  endtask

  task automatic blank_gap(input int n, input int y);
    for (int i = 0; i < n; i++) strobe(1'b0, 0, y, 1'b1, (i < 4) ? 1'b0 : 1'b1, 1'b0);
  endtask

  task automatic run_line(input int y);
    for (int s = 0; s < H + BLANK; s++) begin
      if (y == release_y && s == 50) src_hold = 1'b0;
      if (s < H) strobe(1'b1, s, y, 1'b1, 1'b1, 1'b0);
      else strobe(1'b0, 0, y, !((s - H) >= 20 && (s - H) < 60), 1'b1, 1'b0);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    i_rst = 1'b1; i_pix_stb = 1'b0; i_screenend = 1'b0;
    repeat (n) @(negedge clk);
    i_rst = 1'b0;
    busy = 1'b0; filled[0] = -1; filled[1] = -1;
    exp_underrun = 1'b0; prev_de = 1'b0; line_ok = 1'b1; last_rgb = 16'h0;
    exp_req_q.delete();
  endtask

  task automatic check_reset_outputs();
    chk("rst_req", o_req, 1'b0);
    chk("rst_req_line", o_req_line, 9'd0);
    chk("rst_s_ready", o_s_ready, 1'b0);
    chk("rst_rgb", o_rgb, 16'h0);
    chk("rst_de", o_de, 1'b0);
    chk("rst_hs", o_hs, 1'b1);
    chk("rst_vs", o_vs, 1'b1);
    chk("rst_underrun", o_underrun, 1'b0);
  endtask

  // Upstream pixel source: serves each requested line and checks the handshake
  initial begin
    int  md;
    int  exp_line;
    bit  v;
    i_s_valid = 1'b0;
    i_s_data  = 16'h0;
    wait (src_en);
    forever begin
      @(negedge clk);
      #1;
      if (pending) begin
        pending = 1'b0;
        src_idx++;
        if (src_idx == H) begin
          src_active = 1'b0;
          busy = 1'b0;
          filled[src_line % 2] = src_line;
        end
      end
      if (prev_req) chk("req_pulse", o_req, 1'b0);
      chk("s_ready", o_s_ready, src_active);
      prev_req = o_req;
      if (o_req === 1'b1) begin
        n_req_seen++;
        chk("req_expected", exp_req_q.size() > 0, 1'b1);
        if (exp_req_q.size() > 0) begin
          exp_line = exp_req_q.pop_front();
          chk("req_line", o_req_line, exp_line);
        end
        src_active = 1'b1;
        src_line = int'(o_req_line);
        src_idx = 0;
        tog = 1'b0;
      end
      if (i_rst) begin
        src_active = 1'b0; pending = 1'b0; prev_req = 1'b0; i_s_valid = 1'b0;
      end else begin
        md = (src_line < 8) ? mode_tab[src_line] : M_RAND;
        if (!src_active) v = 1'($urandom_range(1, 0));
        else case (md)
          M_TOGGLE: begin v = tog; tog = !tog; end
          M_STALL:  v = !src_hold;
          M_FULL:   v = 1'b1;
          default:  v = ($urandom_range(3, 0) != 0);
        endcase
        i_s_valid = v;
        i_s_data  = (src_active && v) ? pix(src_line, src_idx) : 16'($urandom);
        pending   = src_active && v && o_s_ready;
      end
    end
  end

  // Main sequence
  initial begin
    int k;
    i_rst = 1'b0; i_pix_stb = 1'b0; i_de = 1'b0; i_hs = 1'b1; i_vs = 1'b1;
    i_screenend = 1'b0; i_x = '0; i_y = '0;
    release_y = -1; src_hold = 1'b0;
    n_req_exp = 0; n_req_seen = 0; act_y = 0;

    // Reset values, then normal frame start with several source patterns
    do_reset(3);
    check_reset_outputs();
    src_en = 1'b1;
    mode_tab[0] = M_RAND; mode_tab[1] = M_FULL; mode_tab[2] = M_TOGGLE;
    mode_tab[3] = M_RAND; mode_tab[4] = M_RAND;
    strobe(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    blank_gap(BLANK, 0);
    for (int y = 0; y < 4; y++) run_line(y);

    // Frame-start trigger while a fill is in progress
    do_reset(2);
    mode_tab[0] = M_RAND; mode_tab[1] = M_FULL;
    strobe(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    blank_gap(200, 0);
    strobe(1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
    blank_gap(700, 0);
    run_line(0);

    // Source withholds line 1 until the line is already on screen
    do_reset(2);
    mode_tab[0] = M_FULL; mode_tab[1] = M_STALL; mode_tab[2] = M_RAND; mode_tab[3] = M_RAND;
    src_hold = 1'b1; release_y = 1;
    strobe(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    blank_gap(BLANK, 0);
    for (int y = 0; y < 3; y++) run_line(y);
    release_y = -1;

    // Reset in the middle of a fill, then a clean refill
    mode_tab[0] = M_RAND; mode_tab[1] = M_RAND;
    strobe(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    k = 0;
    while (src_idx < 400 && k < 2000) begin
      strobe(1'b1, k % H, 3, 1'b0, 1'b0, 1'b0);
      k++;
    end
    chk("mid_fill_reached", src_idx >= 400, 1'b1);
    do_reset(1);
    check_reset_outputs();
    strobe(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    blank_gap(BLANK, 0);
    run_line(0);
    run_line(V - 1);

    chk("req_count", n_req_seen, n_req_exp);
    chk("req_outstanding", exp_req_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
